// File: rtl/constants_pkg.sv
// Shared opcode, FSM state and flag-index definitions for the ALU register file.
package constants_pkg;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_REG_READ,
        OP_REG_WRITE,
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_SHL,
        OP_SHR,
        OP_MUL
    } alu_op_t;

    typedef enum logic {
        ST_IDLE,
        ST_MUL_BUSY
    } state_t;

    // Bit positions inside flags = {V, N, C, Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    function automatic logic sets_flags(input alu_op_t op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_MUL};
    endfunction

endpackage

// File: rtl/alu_regfile_seq_multiplier.sv
// Unsigned shift-add multiplier retiring one multiplier bit per clock.
module seq_multiplier #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [2*DATA_W-1:0] mcand_reg;
    logic [2*DATA_W-1:0] acc_reg;
    logic [DATA_W-1:0]   mplier_reg;
    logic [CNT_W-1:0]    count_reg;
    logic                busy_reg;
    logic                done_reg;

    // Bit 0 is folded in at the start edge so the last step lands DATA_W-1 edges later,
    // letting the caller commit on the DATA_W-th edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_reg  <= '0;
            acc_reg    <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                acc_reg    <= b[0] ? {{DATA_W{1'b0}}, a} : '0;
                mcand_reg  <= {{(DATA_W-1){1'b0}}, a, 1'b0};
                mplier_reg <= b >> 1;
                count_reg  <= CNT_W'(DATA_W - 1);
                busy_reg   <= 1'b1;
            end else if (busy_reg) begin
                if (mplier_reg[0]) begin
                    acc_reg <= acc_reg + mcand_reg;
                end
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                count_reg  <= count_reg - CNT_W'(1);
                if (count_reg == CNT_W'(1)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = acc_reg;

endmodule

// File: rtl/alu_regfile.sv
// Register file fused with a one-stage ALU, operand forwarding, flags and a sequential multiplier.
module alu_regfile
    import constants_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  alu_op_t           op,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] addr_r,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic [3:0]        flags
);

    localparam int SH_W = $clog2(DATA_W);
    localparam logic [ADDR_W:0] REGS_LIMIT = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] reg_we;
    state_t              state_reg, state_next;
    logic                accept;

    logic                ex_valid_reg;
    alu_op_t             ex_op_reg;
    logic [DATA_W-1:0]   ex_a_reg, ex_b_reg;
    logic [ADDR_W-1:0]   ex_addr_reg;
    logic [ADDR_W-1:0]   mul_addr_reg;

    logic [DATA_W-1:0]   opnd_a, opnd_b;
    logic [DATA_W:0]     alu_wide;
    logic [SH_W-1:0]     alu_sh;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_c, alu_v;
    logic [3:0]          flags_next;

    logic                wb_en;
    logic [ADDR_W-1:0]   wb_addr;
    logic [DATA_W-1:0]   wb_data;

    logic                mul_start, mul_busy, mul_done;
    logic [2*DATA_W-1:0] mul_product;

    assign accept    = op_valid && op_ready;
    assign mul_start = accept && (op == OP_MUL);

    seq_multiplier #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (opnd_a),
        .b       (opnd_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        op_ready   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid && op == OP_MUL) state_next = ST_MUL_BUSY;
            end
            ST_MUL_BUSY: if (!mul_busy) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Out-of-range addresses read as zero and never pick up a forwarded (dropped) commit.
    always_comb begin
        opnd_a = '0;
        if ({1'b0, addr_a} < REGS_LIMIT) begin
            opnd_a = (wb_en && wb_addr == addr_a) ? wb_data : regs[addr_a];
        end
    end

    always_comb begin
        opnd_b = '0;
        if ({1'b0, addr_b} < REGS_LIMIT) begin
            opnd_b = (wb_en && wb_addr == addr_b) ? wb_data : regs[addr_b];
        end
    end

    always_comb begin
        alu_wide   = '0;
        alu_sh     = ex_b_reg[SH_W-1:0];
        alu_result = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        case (ex_op_reg)
            OP_REG_WRITE: alu_result = ex_b_reg;
            OP_ADD: begin
                alu_wide   = {1'b0, ex_a_reg} + {1'b0, ex_b_reg};
                alu_result = alu_wide[DATA_W-1:0];
                alu_c      = alu_wide[DATA_W];
                alu_v      = (ex_a_reg[DATA_W-1] == ex_b_reg[DATA_W-1]) &&
                             (alu_result[DATA_W-1] != ex_a_reg[DATA_W-1]);
            end
            OP_SUB: begin
                alu_wide   = {1'b0, ex_a_reg} - {1'b0, ex_b_reg};
                alu_result = alu_wide[DATA_W-1:0];
                alu_c      = alu_wide[DATA_W];
                alu_v      = (ex_a_reg[DATA_W-1] != ex_b_reg[DATA_W-1]) &&
                             (alu_result[DATA_W-1] != ex_a_reg[DATA_W-1]);
            end
            OP_AND: alu_result = ex_a_reg & ex_b_reg;
            OP_OR:  alu_result = ex_a_reg | ex_b_reg;
            OP_XOR: alu_result = ex_a_reg ^ ex_b_reg;
            // The extra guard bit catches the last bit shifted out as the carry.
            OP_SHL: begin
                alu_wide   = {1'b0, ex_a_reg} << alu_sh;
                alu_result = alu_wide[DATA_W-1:0];
                alu_c      = alu_wide[DATA_W];
            end
            OP_SHR: begin
                alu_wide   = {ex_a_reg, 1'b0} >> alu_sh;
                alu_result = alu_wide[DATA_W:1];
                alu_c      = alu_wide[0];
            end
            default: alu_result = '0;
        endcase
    end

    // Multiply commits never overlap a pipelined commit: nothing enters the stage while busy.
    always_comb begin
        wb_en   = 1'b0;
        wb_addr = ex_addr_reg;
        wb_data = alu_result;
        if (mul_done) begin
            wb_en   = 1'b1;
            wb_addr = mul_addr_reg;
            wb_data = mul_product[DATA_W-1:0];
        end else if (ex_valid_reg && ex_op_reg != OP_REG_READ) begin
            wb_en = 1'b1;
        end
    end

    always_comb begin
        flags_next = flags;
        if (mul_done) begin
            flags_next         = '0;
            flags_next[FLAG_Z] = (mul_product[DATA_W-1:0] == '0);
            flags_next[FLAG_N] = mul_product[DATA_W-1];
            flags_next[FLAG_C] = (mul_product[2*DATA_W-1:DATA_W] != '0);
        end else if (ex_valid_reg && sets_flags(ex_op_reg)) begin
            flags_next[FLAG_Z] = (alu_result == '0);
            flags_next[FLAG_N] = alu_result[DATA_W-1];
            flags_next[FLAG_C] = alu_c;
            flags_next[FLAG_V] = alu_v;
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_we
        assign reg_we[gi] = wb_en && (wb_addr == ADDR_W'(gi));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (reset)          regs[i] <= '0;
            else if (reg_we[i]) regs[i] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_reg <= 1'b0;
            ex_op_reg    <= OP_NOP;
            ex_a_reg     <= '0;
            ex_b_reg     <= '0;
            ex_addr_reg  <= '0;
            mul_addr_reg <= '0;
            data_out     <= '0;
            rd_valid     <= 1'b0;
            flags        <= '0;
        end else begin
            ex_valid_reg <= accept && !(op inside {OP_NOP, OP_MUL});
            if (accept) begin
                ex_op_reg   <= op;
                ex_a_reg    <= opnd_a;
                ex_b_reg    <= (op == OP_REG_WRITE) ? data_in : opnd_b;
                ex_addr_reg <= (op inside {OP_REG_WRITE, OP_REG_READ}) ? addr_a : addr_r;
            end
            if (mul_start) mul_addr_reg <= addr_r;
            rd_valid <= ex_valid_reg && (ex_op_reg == OP_REG_READ);
            if (ex_valid_reg && ex_op_reg == OP_REG_READ) data_out <= ex_a_reg;
            flags <= flags_next;
        end
    end

endmodule

// File: tb/tb_alu_regfile.sv
// Directed bench for alu_regfile: 8x8 default instance plus a 16-bit, 6-register instance.
module tb_alu_regfile;
    import constants_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic       op_valid, op_ready, rd_valid;
    alu_op_t    op;
    logic [2:0] addr_a, addr_b, addr_r;
    logic [7:0] data_in, data_out;
    logic [3:0] flags;

    logic        w_op_valid, w_op_ready, w_rd_valid;
    alu_op_t     w_op;
    logic [2:0]  w_addr_a, w_addr_b, w_addr_r;
    logic [15:0] w_data_in, w_data_out;
    logic [3:0]  w_flags;

    int errors = 0;
    int checks = 0;

    alu_regfile #(.DATA_W(8), .NUM_REGS(8)) u_dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .op(op),
        .addr_a(addr_a), .addr_b(addr_b), .addr_r(addr_r), .data_in(data_in),
        .data_out(data_out), .rd_valid(rd_valid), .flags(flags)
    );

    alu_regfile #(.DATA_W(16), .NUM_REGS(6)) u_dut16 (
        .clk(clk), .reset(reset), .op_valid(w_op_valid), .op_ready(w_op_ready), .op(w_op),
        .addr_a(w_addr_a), .addr_b(w_addr_b), .addr_r(w_addr_r), .data_in(w_data_in),
        .data_out(w_data_out), .rd_valid(w_rd_valid), .flags(w_flags)
    );

    task automatic issue8(input alu_op_t o, input logic [2:0] a, input logic [2:0] b,
                          input logic [2:0] r, input logic [7:0] d);
        op = o; addr_a = a; addr_b = b; addr_r = r; data_in = d; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0; op = OP_NOP;
    endtask

    task automatic read8(input logic [2:0] a, output logic [7:0] d, output logic v);
        issue8(OP_REG_READ, a, 3'd0, 3'd0, 8'h00);
        @(posedge clk); #1;
        d = data_out; v = rd_valid;
        $display("dut8  read r%0d -> %h (rd_valid=%b)", a, d, v);
    endtask

    task automatic issue16(input alu_op_t o, input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] r, input logic [15:0] d);
        w_op = o; w_addr_a = a; w_addr_b = b; w_addr_r = r; w_data_in = d; w_op_valid = 1'b1;
        @(posedge clk); #1;
        w_op_valid = 1'b0; w_op = OP_NOP;
    endtask

    task automatic read16(input logic [2:0] a, output logic [15:0] d, output logic v);
        issue16(OP_REG_READ, a, 3'd0, 3'd0, 16'h0000);
        @(posedge clk); #1;
        d = w_data_out; v = w_rd_valid;
        $display("dut16 read r%0d -> %h (rd_valid=%b)", a, d, v);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic       v;
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %h expected 0", flags); end
        @(posedge clk); #1;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_op_ready: got %b expected 1", op_ready); end
        for (int i = 0; i < 8; i++) begin
            read8(3'(i), d, v);
            checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_read r%0d: got %h expected 00", i, d); end
            checks++; if (v !== 1'b1) begin errors++; $display("FAIL reset_read_valid r%0d: got %b expected 1", i, v); end
        end
        @(posedge clk); #1;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rd_valid_pulse: got %b expected 0", rd_valid); end
        checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags_after_reads: got %h expected 0", flags); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic       v;
        int         low_seen = 0;
        if (op_ready !== 1'b1) low_seen++;
        issue8(OP_REG_WRITE, 3'd0, 3'd0, 3'd0, 8'h42);
        if (op_ready !== 1'b1) low_seen++;
        issue8(OP_REG_WRITE, 3'd1, 3'd0, 3'd0, 8'h24);
        if (op_ready !== 1'b1) low_seen++;
        issue8(OP_ADD, 3'd0, 3'd1, 3'd2, 8'h00);
        if (op_ready !== 1'b1) low_seen++;
        $display("dut8  WRITE r0=42, WRITE r1=24, ADD r2=r0+r1");
        read8(3'd2, d, v);
        checks++; if (d !== 8'h66) begin errors++; $display("FAIL b2b_add: got %h expected 66", d); end
        checks++; if (flags !== 4'h0) begin errors++; $display("FAIL b2b_flags: got %h expected 0", flags); end
        checks++; if (low_seen !== 0) begin errors++; $display("FAIL b2b_op_ready: low %0d times expected 0", low_seen); end
    endtask

    task automatic test_fibonacci();
        logic [7:0] d;
        logic       v;
        logic [7:0] fib [8];
        fib[3] = 8'h02; fib[4] = 8'h03; fib[5] = 8'h05; fib[6] = 8'h08; fib[7] = 8'h0D;
        issue8(OP_REG_WRITE, 3'd0, 3'd0, 3'd0, 8'h00);
        issue8(OP_REG_WRITE, 3'd1, 3'd0, 3'd0, 8'h01);
        issue8(OP_REG_WRITE, 3'd2, 3'd0, 3'd0, 8'h01);
        for (int i = 3; i < 8; i++) begin
            issue8(OP_ADD, 3'(i - 2), 3'(i - 1), 3'(i), 8'h00);
            $display("dut8  ADD r%0d=r%0d+r%0d", i, i - 2, i - 1);
        end
        for (int i = 3; i < 8; i++) begin
            read8(3'(i), d, v);
            checks++; if (d !== fib[i]) begin errors++; $display("FAIL fib r%0d: got %h expected %h", i, d, fib[i]); end
        end
    endtask

    typedef struct {
        alu_op_t    o;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [3:0] f;
    } vec_t;

    task automatic test_flags();
        vec_t       vecs [12];
        logic [7:0] d;
        logic       v;
        // flags are {V, N, C, Z}
        vecs[0]  = '{OP_ADD, 8'hFF, 8'h01, 8'h00, 4'h3};
        vecs[1]  = '{OP_SUB, 8'h80, 8'h01, 8'h7F, 4'h8};
        vecs[2]  = '{OP_SUB, 8'h01, 8'h02, 8'hFF, 4'h6};
        vecs[3]  = '{OP_ADD, 8'h7F, 8'h01, 8'h80, 4'hC};
        vecs[4]  = '{OP_SHL, 8'h81, 8'h01, 8'h02, 4'h2};
        vecs[5]  = '{OP_SHR, 8'h81, 8'h01, 8'h40, 4'h2};
        vecs[6]  = '{OP_SHR, 8'h81, 8'h03, 8'h10, 4'h0};
        vecs[7]  = '{OP_SHL, 8'h03, 8'h07, 8'h80, 4'h6};
        vecs[8]  = '{OP_SHL, 8'h01, 8'h08, 8'h01, 4'h0};
        vecs[9]  = '{OP_XOR, 8'h5A, 8'h5A, 8'h00, 4'h1};
        vecs[10] = '{OP_AND, 8'hF0, 8'h3C, 8'h30, 4'h0};
        vecs[11] = '{OP_OR,  8'h80, 8'h01, 8'h81, 4'h4};
        for (int i = 0; i < 12; i++) begin
            issue8(OP_REG_WRITE, 3'd0, 3'd0, 3'd0, vecs[i].a);
            issue8(OP_REG_WRITE, 3'd1, 3'd0, 3'd0, vecs[i].b);
            issue8(vecs[i].o, 3'd0, 3'd1, 3'd2, 8'h00);
            $display("dut8  %s %h,%h", vecs[i].o.name(), vecs[i].a, vecs[i].b);
            read8(3'd2, d, v);
            checks++; if (d !== vecs[i].res) begin errors++; $display("FAIL alu_result vec%0d: got %h expected %h", i, d, vecs[i].res); end
            checks++; if (flags !== vecs[i].f) begin errors++; $display("FAIL alu_flags vec%0d: got %h expected %h", i, flags, vecs[i].f); end
        end
    endtask

    task automatic test_mul();
        logic [7:0] d;
        logic       v;
        int         low_cnt = 0;
        issue8(OP_REG_WRITE, 3'd0, 3'd0, 3'd0, 8'h0D);
        issue8(OP_REG_WRITE, 3'd1, 3'd0, 3'd0, 8'h0B);
        issue8(OP_MUL, 3'd0, 3'd1, 3'd2, 8'h00);
        $display("dut8  MUL r2=r0*r1 with ADD r1=r2+r1 held");
        op = OP_ADD; addr_a = 3'd2; addr_b = 3'd1; addr_r = 3'd1; op_valid = 1'b1;
        while (op_ready === 1'b0 && low_cnt < 40) begin
            low_cnt++;
            @(posedge clk); #1;
        end
        checks++; if (low_cnt !== 8) begin errors++; $display("FAIL mul_busy_cycles: got %0d expected 8", low_cnt); end
        @(posedge clk); #1;
        op_valid = 1'b0; op = OP_NOP;
        checks++; if (flags !== 4'h4) begin errors++; $display("FAIL mul_flags: got %h expected 4", flags); end
        read8(3'd2, d, v);
        checks++; if (d !== 8'h8F) begin errors++; $display("FAIL mul_product: got %h expected 8F", d); end
        read8(3'd1, d, v);
        checks++; if (d !== 8'h9A) begin errors++; $display("FAIL mul_held_add: got %h expected 9A", d); end
    endtask

    task automatic test_mul_reset();
        logic [7:0] d;
        logic       v;
        int         low_seen = 0;
        issue8(OP_REG_WRITE, 3'd0, 3'd0, 3'd0, 8'hFF);
        issue8(OP_REG_WRITE, 3'd1, 3'd0, 3'd0, 8'hFF);
        issue8(OP_MUL, 3'd0, 3'd1, 3'd2, 8'h00);
        repeat (2) begin @(posedge clk); #1; end
        $display("dut8  MUL FF*FF interrupted by reset");
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL mulrst_op_ready: got %b expected 1", op_ready); end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (op_ready !== 1'b1) low_seen++;
        end
        checks++; if (low_seen !== 0) begin errors++; $display("FAIL mulrst_idle: op_ready low %0d times expected 0", low_seen); end
        read8(3'd2, d, v);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL mulrst_no_writeback: got %h expected 00", d); end
        checks++; if (flags !== 4'h0) begin errors++; $display("FAIL mulrst_flags: got %h expected 0", flags); end
    endtask

    task automatic test_depth16();
        logic [15:0] d;
        logic        v;
        int          low_cnt = 0;
        issue16(OP_REG_WRITE, 3'd5, 3'd0, 3'd0, 16'hBEEF);
        issue16(OP_REG_WRITE, 3'd7, 3'd0, 3'd0, 16'h1234);
        issue16(OP_ADD, 3'd7, 3'd5, 3'd4, 16'h0000);
        $display("dut16 WRITE r5=BEEF, WRITE r7=1234, ADD r4=r7+r5");
        read16(3'd7, d, v);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL depth_read_r7: got %h expected 0000", d); end
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL depth_read_r7_valid: got %b expected 1", v); end
        read16(3'd4, d, v);
        checks++; if (d !== 16'hBEEF) begin errors++; $display("FAIL depth_add_r4: got %h expected BEEF", d); end
        checks++; if (w_flags !== 4'h4) begin errors++; $display("FAIL depth_add_flags: got %h expected 4", w_flags); end
        read16(3'd5, d, v);
        checks++; if (d !== 16'hBEEF) begin errors++; $display("FAIL depth_read_r5: got %h expected BEEF", d); end
        issue16(OP_REG_WRITE, 3'd0, 3'd0, 3'd0, 16'h0100);
        issue16(OP_MUL, 3'd0, 3'd0, 3'd1, 16'h0000);
        $display("dut16 MUL r1=r0*r0 (0100*0100)");
        while (w_op_ready === 1'b0 && low_cnt < 60) begin
            low_cnt++;
            @(posedge clk); #1;
        end
        checks++; if (low_cnt !== 16) begin errors++; $display("FAIL depth_mul_cycles: got %0d expected 16", low_cnt); end
        read16(3'd1, d, v);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL depth_mul_low: got %h expected 0000", d); end
        checks++; if (w_flags !== 4'h3) begin errors++; $display("FAIL depth_mul_flags: got %h expected 3", w_flags); end
    endtask

    initial begin
        reset = 1'b1;
        op_valid = 1'b0; op = OP_NOP; addr_a = '0; addr_b = '0; addr_r = '0; data_in = '0;
        w_op_valid = 1'b0; w_op = OP_NOP; w_addr_a = '0; w_addr_b = '0; w_addr_r = '0; w_data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_back_to_back();
        test_fibonacci();
        test_flags();
        test_mul();
        test_mul_reset();
        test_depth16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
